// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC and buffers fetched words in a small FIFO for decode.
// Optional misaligned-redirect detection is compiled in with `define FETCHQ_ALIGN_CHECK_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchEn,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    input  logic        instReady,
    output logic        alignErr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic empty, full, push, pop, halt_fetch;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = ~empty & instReady & ~redirect;
    assign push  = fetchEn & ~redirect & (~full | pop) & ~halt_fetch;

`ifdef FETCHQ_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    // Sticky until a redirect to an aligned PC; while set, fetch is halted.
    always_comb begin
        align_err_d = align_err_q;
        if (redirect) begin
            align_err_d = |redirectPc[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign halt_fetch = align_err_q;
    assign alignErr   = align_err_q;
`else
    logic unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirectPc[1:0];
    assign halt_fetch     = 1'b0;
    assign alignErr       = 1'b0;
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirectPc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is gated to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            data_mem[wr_ptr_q] <= imemData;
        end
    end

    assign imemAddr  = fetch_pc_q;
    assign instValid = ~empty;
    assign inst      = empty ? 32'h0 : data_mem[rd_ptr_q];
    assign instPc    = empty ? 32'h0 : pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected PC streams are queued at reset/redirect, checked on each pop.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchEn;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instReady;
    logic        alignErr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    // Combinational instruction memory: word content derived from its address.
    assign imemData = 32'h1000_0000 | imemAddr;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetchEn   (fetchEn),
        .imemAddr  (imemAddr),
        .imemData  (imemData),
        .redirect  (redirect),
        .redirectPc(redirectPc),
        .instValid (instValid),
        .inst      (inst),
        .instPc    (instPc),
        .instReady (instReady),
        .alignErr  (alignErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic do_reset();
        rst = 1'b1; fetchEn = 1'b0; instReady = 1'b0; redirect = 1'b0; redirectPc = '0;
        tick();
        rst = 1'b0;
        sb_restart(RESET_PC);
    endtask

    // Every accepted instruction is compared with the head of the expected stream.
    always @(negedge clk) begin
        if (!rst && instValid && instReady && !redirect) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got instPc=%h, required no instruction", instPc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb.pop_front();
                if (instPc !== exp_pc || inst !== (32'h1000_0000 | exp_pc)) begin
                    n_fail++;
                    $display("FAIL pop_order: got pc=%h inst=%h, required pc=%h inst=%h",
                             instPc, inst, exp_pc, 32'h1000_0000 | exp_pc);
                end else begin
                    $display("pop pc=%h inst=%h", instPc, inst);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; fetchEn = 1'b0; instReady = 1'b0; redirect = 1'b0; redirectPc = '0;
        #1;
        n_checks++;
        if (instValid !== 1'b0 || inst !== 32'h0 || instPc !== 32'h0 || alignErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b inst=%h pc=%h ae=%b, required 0 0 0 0",
                     instValid, inst, instPc, alignErr);
        end
        n_checks++;
        if (imemAddr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_pc: got %h, required %h", imemAddr, RESET_PC);
        end
        tick(); tick();
        rst = 1'b0;
        sb_restart(RESET_PC);
        tick();
        n_checks++;
        if (instValid !== 1'b0 || imemAddr !== RESET_PC) begin
            n_fail++;
            $display("FAIL idle_no_fetch: got v=%b addr=%h, required 0 %h", instValid, imemAddr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        fetchEn = 1'b1; instReady = 1'b1;
        n_checks++;
        if (instValid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got instValid=%b, required 0", instValid);
        end
        tick();
        n_checks++;
        if (instValid !== 1'b1 || instPc !== 32'h0 || inst !== 32'h1000_0000 || imemAddr !== 32'h4) begin
            n_fail++;
            $display("FAIL first_push: got v=%b pc=%h inst=%h addr=%h, required 1 0 10000000 4",
                     instValid, instPc, inst, imemAddr);
        end
        repeat (4) tick();
        n_checks++;
        if (imemAddr !== 32'h14) begin
            n_fail++;
            $display("FAIL stream_addr: got %h, required 00000014", imemAddr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetchEn = 1'b1; instReady = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (imemAddr !== 32'h10 || instValid !== 1'b1 || instPc !== 32'h0) begin
            n_fail++;
            $display("FAIL full_hold: got addr=%h v=%b pc=%h, required 10 1 0", imemAddr, instValid, instPc);
        end
        instReady = 1'b1;
        tick();
        n_checks++;
        if (imemAddr !== 32'h14 || instPc !== 32'h4) begin
            n_fail++;
            $display("FAIL full_push_pop: got addr=%h pc=%h, required 14 4", imemAddr, instPc);
        end
        repeat (2) tick();
        n_checks++;
        if (imemAddr !== 32'h1C || instPc !== 32'hC) begin
            n_fail++;
            $display("FAIL full_wrap: got addr=%h pc=%h, required 1c c", imemAddr, instPc);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetchEn = 1'b1; instReady = 1'b0;
        repeat (4) tick();
        instReady = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (instPc !== 32'h8 || imemAddr !== 32'h18) begin
            n_fail++;
            $display("FAIL pre_redirect: got pc=%h addr=%h, required 8 18", instPc, imemAddr);
        end
        redirect = 1'b1; redirectPc = 32'h200;
        sb_restart(32'h200);
        tick();
        redirect = 1'b0;
        n_checks++;
        if (instValid !== 1'b0 || imemAddr !== 32'h200) begin
            n_fail++;
            $display("FAIL redirect_flush: got v=%b addr=%h, required 0 200", instValid, imemAddr);
        end
        tick();
        n_checks++;
        if (instValid !== 1'b1 || instPc !== 32'h200) begin
            n_fail++;
            $display("FAIL redirect_first: got v=%b pc=%h, required 1 200", instValid, instPc);
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirectPc = 32'h400;
        tick();
        redirectPc = 32'h500;
        sb_restart(32'h500);
        tick();
        redirect = 1'b0;
        n_checks++;
        if (instValid !== 1'b0 || imemAddr !== 32'h500) begin
            n_fail++;
            $display("FAIL b2b_redirect: got v=%b addr=%h, required 0 500", instValid, imemAddr);
        end
        tick();
        n_checks++;
        if (instPc !== 32'h500) begin
            n_fail++;
            $display("FAIL b2b_first: got pc=%h, required 500", instPc);
        end
        repeat (2) tick();
    endtask

    task automatic test_wrap_and_disable();
        redirect = 1'b1; redirectPc = 32'hFFFF_FFF8;
        sb_restart(32'hFFFF_FFF8);
        tick();
        redirect = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (imemAddr !== 32'h8 || instPc !== 32'h4) begin
            n_fail++;
            $display("FAIL pc_wrap: got addr=%h pc=%h, required 8 4", imemAddr, instPc);
        end
        fetchEn = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (instValid !== 1'b0 || imemAddr !== 32'h8) begin
            n_fail++;
            $display("FAIL fetch_disable: got v=%b addr=%h, required 0 8", instValid, imemAddr);
        end
        fetchEn = 1'b1;
        tick();
        n_checks++;
        if (instValid !== 1'b1 || instPc !== 32'h8) begin
            n_fail++;
            $display("FAIL fetch_resume: got v=%b pc=%h, required 1 8", instValid, instPc);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        fetchEn = 1'b1; instReady = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (instValid !== 1'b0 || inst !== 32'h0 || instPc !== 32'h0 || imemAddr !== RESET_PC) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b inst=%h pc=%h addr=%h, required 0 0 0 %h",
                     instValid, inst, instPc, imemAddr, RESET_PC);
        end
        tick();
        rst = 1'b0; instReady = 1'b1;
        sb_restart(RESET_PC);
        tick();
        n_checks++;
        if (instValid !== 1'b1 || instPc !== RESET_PC) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got v=%b pc=%h, required 1 %h", instValid, instPc, RESET_PC);
        end
        repeat (2) tick();
    endtask

    task automatic test_align();
        fetchEn = 1'b1; instReady = 1'b1;
        redirect = 1'b1; redirectPc = 32'h102;
`ifdef FETCHQ_ALIGN_CHECK_EN
        sb.delete();
`else
        sb_restart(32'h100);
`endif
        tick();
        redirect = 1'b0;
        n_checks++;
`ifdef FETCHQ_ALIGN_CHECK_EN
        if (alignErr !== 1'b1 || imemAddr !== 32'h100) begin
            n_fail++;
            $display("FAIL align_set: got ae=%b addr=%h, required 1 100", alignErr, imemAddr);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (instValid !== 1'b0 || imemAddr !== 32'h100 || alignErr !== 1'b1) begin
                n_fail++;
                $display("FAIL align_halt: got v=%b addr=%h ae=%b, required 0 100 1", instValid, imemAddr, alignErr);
            end
        end
`else
        if (alignErr !== 1'b0 || imemAddr !== 32'h100) begin
            n_fail++;
            $display("FAIL align_off: got ae=%b addr=%h, required 0 100", alignErr, imemAddr);
        end
        tick();
        n_checks++;
        if (instValid !== 1'b1 || instPc !== 32'h100) begin
            n_fail++;
            $display("FAIL align_off_fetch: got v=%b pc=%h, required 1 100", instValid, instPc);
        end
`endif
        redirect = 1'b1; redirectPc = 32'h300;
        sb_restart(32'h300);
        tick();
        redirect = 1'b0;
        n_checks++;
        if (alignErr !== 1'b0) begin
            n_fail++;
            $display("FAIL align_clear: got ae=%b, required 0", alignErr);
        end
        tick();
        n_checks++;
        if (instValid !== 1'b1 || instPc !== 32'h300) begin
            n_fail++;
            $display("FAIL align_restart: got v=%b pc=%h, required 1 300", instValid, instPc);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap_and_disable();
        test_async_reset();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule
